// File: rtl/uart_tx_param.sv
// uart_tx_param -- parametrised UART transmitter with internal baud divider.
//
// Frame: start bit (0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit lasts DIV = round(CLK_HZ / BAUD) clocks.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active low
//   tx_data   in   [DATA_BITS-1:0] word to send, latched at acceptance
//   tx_valid  in   producer has a word
//   tx_ready  out  high only in IDLE; word accepted on tx_valid & tx_ready
//   tx        out  serial line, idle high, driven from a flop
//   busy      out  frame in progress (cycle after accept through done cycle)
//   done      out  one-cycle pulse on the last clock of the final stop bit
module uart_tx_param #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx_r;
    logic                 bit_end;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
    assign tx       = tx_r;

    // tx_r is loaded with the value of the *next* bit at each bit boundary,
    // so the line changes exactly on the boundary edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_r     <= 1'b1;
        end else if (state == S_IDLE) begin
            if (tx_valid) begin
                state    <= S_START;
                tx_r     <= 1'b0;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= tx_data;
                par_bit  <= (PARITY == 1) ? ~^tx_data : ^tx_data;
            end
        end else if (!bit_end) begin
            baud_cnt <= baud_cnt + CW'(1);
        end else begin
            baud_cnt <= '0;
            case (state)
                S_START: begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                    tx_r    <= shreg[0];
                end
                S_DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        if (PARITY != 0) begin
                            state <= S_PARITY;
                            tx_r  <= par_bit;
                        end else begin
                            state <= S_STOP;
                            tx_r  <= 1'b1;
                        end
                    end else begin
                        // shift so the next data bit is always at index 1
                        bit_cnt <= bit_cnt + 4'd1;
                        tx_r    <= shreg[1];
                        shreg   <= shreg >> 1;
                    end
                end
                S_PARITY: begin
                    state   <= S_STOP;
                    bit_cnt <= '0;
                    tx_r    <= 1'b1;
                end
                S_STOP: begin
                    if (bit_cnt == STOP_LAST) begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    tx_r <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    tx_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param -- directed, scoreboarded bench for uart_tx_param.
// Four instances (8N1, 8E1, 8O1, 7O2) at DIV = 10 share clock and reset;
// `sel` chooses which instance the stimulus and checks address.
module tb_uart_tx_param;

    localparam int DIV = 10;   // 50 MHz / 5 MHz

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] d8_0, d8_1, d8_2;
    logic [6:0] d7_3;
    logic [3:0] vld;
    logic tx_0, tx_1, tx_2, tx_3;
    logic rdy_0, rdy_1, rdy_2, rdy_3;
    logic bsy_0, bsy_1, bsy_2, bsy_3;
    logic dn_0, dn_1, dn_2, dn_3;
    logic s_tx, s_rdy, s_bsy, s_dn;
    int   sel = 0;
    int   tests = 0;
    int   fails = 0;
    logic exp_q [$];

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst_n(rst_n), .tx_data(d8_0), .tx_valid(vld[0]), .tx_ready(rdy_0),
           .tx(tx_0), .busy(bsy_0), .done(dn_0));
    uart_tx_param #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst_n(rst_n), .tx_data(d8_1), .tx_valid(vld[1]), .tx_ready(rdy_1),
           .tx(tx_1), .busy(bsy_1), .done(dn_1));
    uart_tx_param #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst_n(rst_n), .tx_data(d8_2), .tx_valid(vld[2]), .tx_ready(rdy_2),
           .tx(tx_2), .busy(bsy_2), .done(dn_2));
    uart_tx_param #(.CLK_HZ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2))
    u_7o2 (.clk(clk), .rst_n(rst_n), .tx_data(d7_3), .tx_valid(vld[3]), .tx_ready(rdy_3),
           .tx(tx_3), .busy(bsy_3), .done(dn_3));

    always_comb begin
        s_tx = tx_0; s_rdy = rdy_0; s_bsy = bsy_0; s_dn = dn_0;
        case (sel)
            1: begin s_tx = tx_1; s_rdy = rdy_1; s_bsy = bsy_1; s_dn = dn_1; end
            2: begin s_tx = tx_2; s_rdy = rdy_2; s_bsy = bsy_2; s_dn = dn_2; end
            3: begin s_tx = tx_3; s_rdy = rdy_3; s_bsy = bsy_3; s_dn = dn_3; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (inst %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic set_data(input logic [7:0] v);
        case (sel)
            0: d8_0 = v;
            1: d8_1 = v;
            2: d8_2 = v;
            default: d7_3 = v[6:0];
        endcase
    endtask

    task automatic set_valid(input logic v);
        vld[sel[1:0]] = v;
    endtask

    // Expected line bits of one frame go to the scoreboard; returns bit count.
    function automatic int push_frame(input int db, input int par, input int sb, input logic [7:0] v);
        logic p;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            exp_q.push_back(v[i]);
            p = p ^ v[i];
        end
        if (par != 0) exp_q.push_back(par == 1 ? ~p : p);
        for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
        return 1 + db + (par != 0 ? 1 : 0) + sb;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of frame cycle 0.
    task automatic accept(input logic [7:0] v, input logic hold);
        set_data(v);
        set_valid(1'b1);
        chk("ready_before_accept", s_rdy, 1'b1);
        chk("tx_idle_before_accept", s_tx, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) set_valid(1'b0);
    endtask

    // Checks every cycle of a frame against the scoreboard, then the idle
    // cycle that follows. Optionally pokes tx_valid/tx_data at cycle `glitch`.
    task automatic run_frame(input int nbits, input int glitch);
        logic cur;
        int   len;
        cur = 1'b1;
        len = nbits * DIV;
        for (int c = 0; c < len; c++) begin
            if (c % DIV == 0) begin
                chk("scoreboard_nonempty", 8'(exp_q.size() != 0), 8'd1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
            end
            chk("tx", s_tx, cur);
            chk("busy", s_bsy, 1'b1);
            chk("ready_busy", s_rdy, 1'b0);
            chk("done", s_dn, c == len - 1);
            if (glitch >= 0 && c == glitch) begin
                set_data(8'h96);
                set_valid(1'b1);
            end
            if (glitch >= 0 && c == glitch + 1) set_valid(1'b0);
            @(negedge clk);
        end
        chk("tx_after_done", s_tx, 1'b1);
        chk("busy_after_done", s_bsy, 1'b0);
        chk("ready_after_done", s_rdy, 1'b1);
        chk("done_after_done", s_dn, 1'b0);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx", s_tx, 1'b1);
            chk("idle_busy", s_bsy, 1'b0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        d8_0 = '0; d8_1 = '0; d8_2 = '0; d7_3 = '0; vld = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #0;
            chk("rst_tx", s_tx, 1'b1);
            chk("rst_ready", s_rdy, 1'b1);
            chk("rst_busy", s_bsy, 1'b0);
            chk("rst_done", s_dn, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0x55
        sel = 0;
        n = push_frame(8, 0, 1, 8'h55);
        accept(8'h55, 1'b0);
        run_frame(n, -1);
        @(negedge clk);

        // 8E1 0x07 -> parity 1
        sel = 1;
        n = push_frame(8, 2, 1, 8'h07);
        accept(8'h07, 1'b0);
        run_frame(n, -1);
        @(negedge clk);

        // 8O1 0x07 -> parity 0
        sel = 2;
        n = push_frame(8, 1, 1, 8'h07);
        accept(8'h07, 1'b0);
        run_frame(n, -1);
        @(negedge clk);

        // 7O2 0x7F -> parity 0, two stop bits
        sel = 3;
        n = push_frame(7, 1, 2, 8'h7F);
        accept(8'h7F, 1'b0);
        run_frame(n, -1);
        @(negedge clk);

        // Back-to-back with tx_valid held; 0x3C appears right after 0xA5 is taken
        sel = 0;
        n  = push_frame(8, 0, 1, 8'hA5);
        n2 = push_frame(8, 0, 1, 8'h3C);
        accept(8'hA5, 1'b1);
        set_data(8'h3C);
        run_frame(n, -1);
        @(negedge clk);
        run_frame(n2, -1);
        set_valid(1'b0);
        idle_check(15);

        // tx_data changed and tx_valid pulsed mid-frame: no effect, no extra frame
        sel = 1;
        n = push_frame(8, 2, 1, 8'h3A);
        accept(8'h3A, 1'b0);
        run_frame(n, 37);
        idle_check(25);

        // Reset at clk 35 of a frame, then a clean 0x81 frame
        sel = 0;
        accept(8'hC3, 1'b0);
        repeat (35) @(negedge clk);
        chk("tx_before_reset", s_tx, 1'b0);   // cycle 35 = data bit 2 of 0xC3
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", s_tx, 1'b1);
        chk("async_rst_ready", s_rdy, 1'b1);
        chk("async_rst_busy", s_bsy, 1'b0);
        chk("async_rst_done", s_dn, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(3);
        @(negedge clk);
        n = push_frame(8, 0, 1, 8'h81);
        accept(8'h81, 1'b0);
        run_frame(n, -1);
        idle_check(5);

        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
